// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x XLEN architectural register file with a writeback FIFO and a
//   per-register busy scoreboard for the R-type execute interface.
//
//   Issue side : iRS1/iRS2 are read combinationally onto oRS1_DATA/oRS2_DATA.
//                oISSUE_READY is low while rs1, rs2 or rd is pending. A fired
//                issue (iISSUE_VALID && oISSUE_READY) marks rd busy.
//   Writeback  : iWB_VALID/iWB_RD/iWB_DATA are pushed into a WB_DEPTH-entry
//                FIFO when oWB_READY (not full) is high.
//   Commit     : the FIFO head is written to the array every cycle the FIFO
//                is non-empty, and its busy bit is cleared.
//   oBUSY      : scoreboard, bit n set while xn has an outstanding producer.
//
//   Reset is synchronous and active-high on iRST. It clears the array, the
//   scoreboard and the FIFO pointers, and overrides any same-cycle activity.
//
//   Optional macro REGFILE_COMMIT_BYPASS_EN: forwards the committing FIFO
//   head to the read ports and hides its busy bit from the issue check, so a
//   dependent instruction can issue in the commit cycle instead of the next.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int WB_DEPTH = 2
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [4:0]      iRS1,
  input  logic [4:0]      iRS2,
  output logic [XLEN-1:0] oRS1_DATA,
  output logic [XLEN-1:0] oRS2_DATA,
  input  logic            iISSUE_VALID,
  input  logic [4:0]      iISSUE_RD,
  output logic            oISSUE_READY,
  input  logic            iWB_VALID,
  input  logic [4:0]      iWB_RD,
  input  logic [XLEN-1:0] iWB_DATA,
  output logic            oWB_READY,
  output logic [31:0]     oBUSY
);

  localparam int AW = $clog2(WB_DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] regs [32];
  logic [31:0]     busy;

  logic [4:0]      fifoRd   [WB_DEPTH];
  logic [XLEN-1:0] fifoData [WB_DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;

  logic            fifoFull;
  logic            fifoEmpty;
  logic            commitValid;
  logic [4:0]      headRd;
  logic [XLEN-1:0] headData;

  logic [31:0]     busyEff;
  logic            issueFire;
  logic            wbAccept;
  logic [31:0]     setMask;
  logic [31:0]     clearMask;
  logic [31:0]     busyNext;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign fifoFull    = (wrPtr[PW-1] != rdPtr[PW-1]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign fifoEmpty   = (wrPtr == rdPtr);
  assign commitValid = !fifoEmpty;
  assign headRd      = fifoRd[rdPtr[AW-1:0]];
  assign headData    = fifoData[rdPtr[AW-1:0]];

  // Read ports; x0 is hard-wired to zero regardless of array contents.
  always_comb begin
    oRS1_DATA = (iRS1 == 5'd0) ? '0 : regs[iRS1];
    oRS2_DATA = (iRS2 == 5'd0) ? '0 : regs[iRS2];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commitValid && (headRd != 5'd0)) begin
      if (headRd == iRS1) oRS1_DATA = headData;
      if (headRd == iRS2) oRS2_DATA = headData;
    end
`endif
  end

  // Busy view used by the issue check. With bypass, the register being
  // committed this cycle is already readable, so it no longer blocks issue.
  always_comb begin
    busyEff = busy;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commitValid) busyEff[headRd] = 1'b0;
`endif
    busyEff[0] = 1'b0;
  end

  // WAW term (rd busy) keeps two writebacks to one register in issue order.
  assign oISSUE_READY = !busyEff[iRS1] && !busyEff[iRS2] && !busyEff[iISSUE_RD];
  assign oWB_READY    = !fifoFull;
  assign oBUSY        = busy;

  assign issueFire = iISSUE_VALID && oISSUE_READY;
  assign wbAccept  = iWB_VALID && !fifoFull;

  // Set is applied after clear so a new producer keeps ownership of rd when
  // its previous value commits in the same cycle.
  assign setMask   = (issueFire && (iISSUE_RD != 5'd0)) ? (32'd1 << iISSUE_RD) : 32'd0;
  assign clearMask = commitValid ? (32'd1 << headRd) : 32'd0;
  assign busyNext  = (busy & ~clearMask) | setMask;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      busy  <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      busy <= busyNext;
      if (commitValid) begin
        if (headRd != 5'd0) regs[headRd] <= headData;
        rdPtr <= rdPtr + 1'b1;
      end
      if (wbAccept) wrPtr <= wrPtr + 1'b1;
    end
  end

  // FIFO payload needs no reset: entries are only read between the pointers.
  always_ff @(posedge iCLK) begin
    if (wbAccept) begin
      fifoRd[wrPtr[AW-1:0]]   <= iWB_RD;
      fifoData[wrPtr[AW-1:0]] <= iWB_DATA;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_regfile_scoreboard;

  localparam int XLEN     = 32;
  localparam int WB_DEPTH = 2;
`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            iCLK;
  logic            iRST;
  logic [4:0]      iRS1;
  logic [4:0]      iRS2;
  logic [XLEN-1:0] oRS1_DATA;
  logic [XLEN-1:0] oRS2_DATA;
  logic            iISSUE_VALID;
  logic [4:0]      iISSUE_RD;
  logic            oISSUE_READY;
  logic            iWB_VALID;
  logic [4:0]      iWB_RD;
  logic [XLEN-1:0] iWB_DATA;
  logic            oWB_READY;
  logic [31:0]     oBUSY;

  regfile_scoreboard #(.XLEN(XLEN), .WB_DEPTH(WB_DEPTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRS1(iRS1), .iRS2(iRS2),
    .oRS1_DATA(oRS1_DATA), .oRS2_DATA(oRS2_DATA),
    .iISSUE_VALID(iISSUE_VALID), .iISSUE_RD(iISSUE_RD), .oISSUE_READY(oISSUE_READY),
    .iWB_VALID(iWB_VALID), .iWB_RD(iWB_RD), .iWB_DATA(iWB_DATA),
    .oWB_READY(oWB_READY), .oBUSY(oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural registers, set of pending destinations,
  // and an ordered queue of accepted-but-uncommitted writebacks.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic [XLEN-1:0] mRegs [32];
  logic [31:0]     mBusy;
  wb_t             mQ[$];

  function automatic logic [XLEN-1:0] mRead(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (BYP && mQ.size() > 0 && mQ[0].rd == idx) return mQ[0].data;
    return mRegs[idx];
  endfunction

  function automatic bit mIsBusy(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    if (BYP && mQ.size() > 0 && mQ[0].rd == idx) return 1'b0;
    return mBusy[idx];
  endfunction

  function automatic bit mReady();
    return !mIsBusy(iRS1) && !mIsBusy(iRS2) && !mIsBusy(iISSUE_RD);
  endfunction

  function automatic bit mWbReady();
    return mQ.size() < WB_DEPTH;
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic modelEdge();
    bit  rdy;
    bit  acc;
    wb_t h;
    wb_t e;
    if (iRST) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mBusy = '0;
      mQ.delete();
      return;
    end
    rdy = mReady();
    acc = iWB_VALID && mWbReady();
    if (mQ.size() > 0) begin
      h = mQ.pop_front();
      if (h.rd != 5'd0) mRegs[h.rd] = h.data;
      mBusy[h.rd] = 1'b0;
    end
    if (acc) begin
      e.rd   = iWB_RD;
      e.data = iWB_DATA;
      mQ.push_back(e);
    end
    if (iISSUE_VALID && rdy && iISSUE_RD != 5'd0) mBusy[iISSUE_RD] = 1'b1;
  endtask

  task automatic setIn(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd);
    @(negedge iCLK);
    iRST = rst; iRS1 = rs1; iRS2 = rs2;
    iISSUE_VALID = iv; iISSUE_RD = ird;
    iWB_VALID = wv; iWB_RD = wrd; iWB_DATA = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge iCLK);
    modelEdge();
  endtask

  task automatic test_reset();
    setIn(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(0, 5, 0, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== 32'd0) begin failures++; $display("FAIL reset_rs1 got=%h exp=0", oRS1_DATA); end
    checks++; if (oRS2_DATA !== 32'd0) begin failures++; $display("FAIL reset_rs2 got=%h exp=0", oRS2_DATA); end
    checks++; if (oBUSY !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", oBUSY); end
    checks++; if (oWB_READY !== 1'b1) begin failures++; $display("FAIL reset_wbready got=%b exp=1", oWB_READY); end
    checks++; if (oISSUE_READY !== 1'b1) begin failures++; $display("FAIL reset_issueready got=%b exp=1", oISSUE_READY); end
  endtask

  task automatic test_issue_commit();
    logic [XLEN-1:0] expD;
    setIn(0, 0, 0, 1, 3, 0, 0, 0);
    checks++; if (oISSUE_READY !== 1'b1) begin failures++; $display("FAIL ic_issue got=%b exp=1", oISSUE_READY); end
    tick();
    setIn(0, 3, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    checks++; if (oBUSY !== 32'h8) begin failures++; $display("FAIL ic_busy_set got=%h exp=8", oBUSY); end
    checks++; if (oWB_READY !== 1'b1) begin failures++; $display("FAIL ic_wbready got=%b exp=1", oWB_READY); end
    tick();
    // Commit cycle: head of FIFO is x3 but the commit edge has not happened.
    setIn(0, 3, 0, 1, 0, 0, 0, 0);
    checks++; if (oBUSY[3] !== 1'b1) begin failures++; $display("FAIL ic_busy_hold got=%b exp=1", oBUSY[3]); end
    checks++; if (oISSUE_READY !== BYP) begin failures++; $display("FAIL ic_raw_stall got=%b exp=%b", oISSUE_READY, BYP); end
    expD = BYP ? 32'hDEADBEEF : 32'd0;
    checks++; if (oRS1_DATA !== expD) begin failures++; $display("FAIL ic_commit_read got=%h exp=%h", oRS1_DATA, expD); end
    tick();
    setIn(0, 3, 0, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== 32'hDEADBEEF) begin failures++; $display("FAIL ic_x3 got=%h exp=deadbeef", oRS1_DATA); end
    checks++; if (oBUSY !== 32'd0) begin failures++; $display("FAIL ic_busy_clr got=%h exp=0", oBUSY); end
    checks++; if (oISSUE_READY !== 1'b1) begin failures++; $display("FAIL ic_ready_after got=%b exp=1", oISSUE_READY); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] v [4];
    logic [4:0]      rds [3];
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd4;
    for (int k = 0; k < 4; k++) v[k] = $urandom;
    for (int k = 0; k < 3; k++) begin
      setIn(0, 0, 0, 0, 0, 1, rds[k], v[k]);
      checks++; if (oWB_READY !== mWbReady()) begin failures++; $display("FAIL b2b_wbready%0d got=%b exp=%b", k, oWB_READY, mWbReady()); end
      tick();
    end
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(0, 1, 2, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== v[0]) begin failures++; $display("FAIL b2b_x1 got=%h exp=%h", oRS1_DATA, v[0]); end
    checks++; if (oRS2_DATA !== v[1]) begin failures++; $display("FAIL b2b_x2 got=%h exp=%h", oRS2_DATA, v[1]); end
    setIn(0, 4, 0, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== v[2]) begin failures++; $display("FAIL b2b_x4 got=%h exp=%h", oRS1_DATA, v[2]); end
    // Two writebacks to one register: the later one must win.
    setIn(0, 0, 0, 0, 0, 1, 5, v[3]);
    tick();
    setIn(0, 0, 0, 0, 0, 1, 5, ~v[3]);
    tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(0, 5, 0, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== ~v[3]) begin failures++; $display("FAIL b2b_order got=%h exp=%h", oRS1_DATA, ~v[3]); end
  endtask

  task automatic test_x0();
    setIn(0, 0, 0, 1, 0, 1, 0, 32'h12345678);
    checks++; if (oISSUE_READY !== 1'b1) begin failures++; $display("FAIL x0_issue got=%b exp=1", oISSUE_READY); end
    tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (oBUSY[0] !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", oBUSY[0]); end
    tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== 32'd0) begin failures++; $display("FAIL x0_read got=%h exp=0", oRS1_DATA); end
    checks++; if (oBUSY !== 32'd0) begin failures++; $display("FAIL x0_busy_all got=%h exp=0", oBUSY); end
  endtask

  task automatic test_reset_mid();
    setIn(0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    setIn(0, 0, 0, 0, 0, 1, 9, 32'hCAFEF00D);
    tick();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (oBUSY[7] !== 1'b1) begin failures++; $display("FAIL rm_busy7 got=%b exp=1", oBUSY[7]); end
    // Reset with an entry pending and competing issue/writeback traffic.
    setIn(1, 0, 0, 1, 8, 1, 7, 32'h55555555);
    tick();
    setIn(0, 7, 9, 0, 0, 0, 0, 0);
    checks++; if (oRS1_DATA !== 32'd0) begin failures++; $display("FAIL rm_x7 got=%h exp=0", oRS1_DATA); end
    checks++; if (oRS2_DATA !== 32'd0) begin failures++; $display("FAIL rm_x9 got=%h exp=0", oRS2_DATA); end
    checks++; if (oBUSY !== 32'd0) begin failures++; $display("FAIL rm_busy got=%h exp=0", oBUSY); end
    checks++; if (oWB_READY !== 1'b1) begin failures++; $display("FAIL rm_wbready got=%b exp=1", oWB_READY); end
    tick();
    setIn(0, 7, 9, 0, 0, 0, 0, 0);
    checks++; if (oRS2_DATA !== 32'd0) begin failures++; $display("FAIL rm_discard got=%h exp=0", oRS2_DATA); end
  endtask

  task automatic test_random();
    logic            rst;
    logic [4:0]      rs1, rs2, ird, wrd;
    logic            iv, wv;
    logic [XLEN-1:0] wd;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      ird = 5'($urandom_range(0, 7));
      wrd = 5'($urandom_range(0, 7));
      iv  = 1'($urandom_range(0, 1));
      wv  = ($urandom_range(0, 9) < 6);
      wd  = $urandom;
      setIn(rst, rs1, rs2, iv, ird, wv, wrd, wd);
      checks++; if (oRS1_DATA !== mRead(iRS1)) begin failures++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, oRS1_DATA, mRead(iRS1)); end
      checks++; if (oRS2_DATA !== mRead(iRS2)) begin failures++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, oRS2_DATA, mRead(iRS2)); end
      checks++; if (oISSUE_READY !== mReady()) begin failures++; $display("FAIL rnd_issue n=%0d got=%b exp=%b", n, oISSUE_READY, mReady()); end
      checks++; if (oWB_READY !== mWbReady()) begin failures++; $display("FAIL rnd_wbready n=%0d got=%b exp=%b", n, oWB_READY, mWbReady()); end
      checks++; if (oBUSY !== mBusy) begin failures++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, oBUSY, mBusy); end
      tick();
    end
  endtask

  initial begin
    iRST = 1'b1; iRS1 = '0; iRS2 = '0;
    iISSUE_VALID = 1'b0; iISSUE_RD = '0;
    iWB_VALID = 1'b0; iWB_RD = '0; iWB_DATA = '0;
    mBusy = '0;
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    test_reset();
    test_issue_commit();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
